vc_buffer_multi: RTL and testbench
==================================

// Module: vc_buffer_multi
// PURPOSE
//  Multi-virtual-channel input buffer for one router input port: NUM_VC independent circular FIFOs of
//  2**ADDR_W flits each, DATA_W bits wide, sharing one write port and one read port in a single clock
//  domain. Adds per-VC status, almost-full, credit-return pulses and sticky per-VC error flags.
//  Sits between the link receiver (write side) and the VC allocator/switch (read side).
// PARAMETERS
//  DATA_W     32  flit width in bits
//  ADDR_W     4   log2 of per-VC depth; DEPTH = 2**ADDR_W (16)
//  NUM_VC     4   number of virtual channels (1..2**VC_W)
//  VC_W       2   width of the VC index ports
//  AF_THRESH  14  almost_full asserts when ocup >= AF_THRESH (1..DEPTH)
// PORTS
//  clk          in   1                   clock, all state on posedge
//  reset        in   1                   asynchronous, active-low reset
//  wr_en        in   1                   write request
//  wr_vc        in   VC_W                target VC of write
//  wr_data      in   DATA_W              flit to write
//  rd_en        in   1                   pop request
//  rd_vc        in   VC_W                VC to read/pop
//  rd_data      out  DATA_W              head flit of rd_vc (0 if that VC is empty)
//  rd_valid     out  1                   rd_vc valid and non-empty
//  full         out  NUM_VC              per-VC full
//  empty        out  NUM_VC              per-VC empty
//  almost_full  out  NUM_VC              per-VC ocup >= AF_THRESH
//  ocup         out  NUM_VC*(ADDR_W+1)   per-VC occupancy, VC v at [v*(ADDR_W+1) +: ADDR_W+1]
//  credit_out   out  NUM_VC              registered one-cycle pulse per successful pop
//  err          out  NUM_VC              sticky per-VC overflow/underflow flag
//  err_clr      in   1                   synchronous clear of all err bits
// BEHAVIOUR
//  - Per VC: wr_ptr/rd_ptr of ADDR_W+1 bits; empty = ptrs equal; full = low bits equal, MSB differs;
//    ocup = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)), range 0..DEPTH.
//  - Reset (reset low, async): all pointers 0, credit_out=0, err=0; hence empty=all 1, full=0,
//    almost_full=0, ocup=0, rd_data=0, rd_valid=0. Storage contents are not reset (don't-care).
//  - Write accepted iff wr_en & wr_vc<NUM_VC & ~full[wr_vc]; flit stored at wr_ptr, wr_ptr+1 on edge.
//  - Pop accepted iff rd_en & rd_vc<NUM_VC & ~empty[rd_vc]; rd_ptr+1 on edge.
//  - Read is first-word fall-through: rd_data/rd_valid combinational from rd_vc and current state,
//    zero latency; a flit written at edge N is visible on rd_data after edge N.
//  - Full/empty use pre-edge state: write to a full VC is rejected even if that VC pops same cycle;
//    pop of an empty VC is rejected even if that VC is written same cycle.
//  - Simultaneous accepted write+pop on same VC: ocup unchanged; on different VCs: independent.
//  - Pointers wrap modulo 2**(ADDR_W+1); no special case at wrap.
//  - err[v] set on edge when (wr_en & wr_vc==v & full[v]) or (rd_en & rd_vc==v & empty[v]);
//    stays set until err_clr or reset; a set event in the err_clr cycle wins (bit stays 1).
//  - wr_vc/rd_vc >= NUM_VC: request ignored, no state change, no err bit, rd_data=0, rd_valid=0.
//  - credit_out[v] = 1 for exactly the cycle after an accepted pop of VC v; at most one bit per cycle.
//  - Reset asserted mid-traffic: all VCs empty immediately; in-flight pops give no credit pulse.
// TESTING
//  1 Reset low then high, idle -> empty=4'b1111, full=0, ocup all 0, err=0, credit_out=0, rd_data=0.
//  2 Write 16 flits 0x100..0x10F to VC2, 17th write -> full[2]=1 after 16th, almost_full[2]=1 from
//    14th, 17th dropped, err[2]=1, ocup[2]=16; pop 16 with rd_vc=2 -> rd_data 0x100..0x10F in order,
//    credit_out[2] pulses 16 times one cycle after each pop, ends empty.
//  3 VC1 holds 3 flits; same cycle write VC1 + pop VC1 -> ocup[1] stays 3; write VC0 + pop VC1 ->
//    ocup[0]+1, ocup[1]-1.
//  4 Pop empty VC3 -> err[3]=1, pointers unchanged; err_clr pulse -> err=0; err_clr with a new
//    underflow same cycle -> err[3] stays 1.
//  5 Run 40 write/pop pairs through VC0 (pointer wrap twice) -> data order preserved, no false full/empty.
//  6 Fill VC2 with 5 flits, assert reset low mid-cycle -> empty[2]=1, ocup[2]=0 without a clock edge.

Source files
------------

// File: rtl/vc_buffer_multi.sv
// Multi-VC input buffer: NUM_VC circular FIFOs sharing one write and one read port.
// Provides first-word fall-through reads, per-VC status, credit-return pulses and sticky error flags.
module vc_buffer_multi #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_VC    = 4,
    parameter int VC_W      = 2,
    parameter int AF_THRESH = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [VC_W-1:0]              wr_vc,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic [VC_W-1:0]              rd_vc,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic [NUM_VC-1:0]            full,
    output logic [NUM_VC-1:0]            empty,
    output logic [NUM_VC-1:0]            almost_full,
    output logic [NUM_VC*(ADDR_W+1)-1:0] ocup,
    output logic [NUM_VC-1:0]            credit_out,
    output logic [NUM_VC-1:0]            err,
    input  logic                         err_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = ADDR_W + 1;

    logic [PW-1:0]     wr_ptr_q [NUM_VC];
    logic [PW-1:0]     wr_ptr_d [NUM_VC];
    logic [PW-1:0]     rd_ptr_q [NUM_VC];
    logic [PW-1:0]     rd_ptr_d [NUM_VC];
    logic [PW-1:0]     occ_w    [NUM_VC];
    logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];

    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] rd_sel;
    logic [NUM_VC-1:0] full_w;
    logic [NUM_VC-1:0] empty_w;
    logic [NUM_VC-1:0] wr_acc;
    logic [NUM_VC-1:0] rd_acc;
    logic [NUM_VC-1:0] err_set;
    logic [NUM_VC-1:0] err_q;
    logic [NUM_VC-1:0] err_d;
    logic [NUM_VC-1:0] credit_q;

    // Handshake: write and pop are single-cycle requests with no ready signal. A request is taken
    // on the edge where its VC index decodes to an existing VC and that VC is not full (write) or
    // not empty (pop), judged on pre-edge state; full/empty act as the per-VC ready indication.
    always_comb begin
        wr_sel  = '0;
        rd_sel  = '0;
        full_w  = '0;
        empty_w = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v]  = wr_en && (wr_vc == VC_W'(v));
            rd_sel[v]  = rd_en && (rd_vc == VC_W'(v));
            empty_w[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full_w[v]  = (wr_ptr_q[v][ADDR_W-1:0] == rd_ptr_q[v][ADDR_W-1:0]) &&
                         (wr_ptr_q[v][ADDR_W] != rd_ptr_q[v][ADDR_W]);
        end
        wr_acc  = wr_sel & ~full_w;
        rd_acc  = rd_sel & ~empty_w;
        err_set = (wr_sel & full_w) | (rd_sel & empty_w);
        err_d   = (err_q & ~{NUM_VC{err_clr}}) | err_set;
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_acc[v] ? wr_ptr_q[v] + PW'(1) : wr_ptr_q[v];
            rd_ptr_d[v] = rd_acc[v] ? rd_ptr_q[v] + PW'(1) : rd_ptr_q[v];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            err_q    <= '0;
            credit_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
            err_q    <= err_d;
            credit_q <= rd_acc;
        end
    end

    // Flit storage carries no reset; empty VCs never expose it.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_acc[v]) begin
                mem_q[v][wr_ptr_q[v][ADDR_W-1:0]] <= wr_data;
            end
        end
    end

    always_comb begin
        ocup        = '0;
        almost_full = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occ_w[v]            = wr_ptr_q[v] - rd_ptr_q[v];
            ocup[v*PW +: PW]    = occ_w[v];
            almost_full[v]      = (occ_w[v] >= PW'(AF_THRESH));
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if ((rd_vc == VC_W'(v)) && !empty_w[v]) begin
                rd_data  = mem_q[v][rd_ptr_q[v][ADDR_W-1:0]];
                rd_valid = 1'b1;
            end
        end
    end

    assign full       = full_w;
    assign empty      = empty_w;
    assign credit_out = credit_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vc_buffer_multi.sv
// Directed bench for vc_buffer_multi: per-VC queue model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_vc_buffer_multi;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int AF_TH  = 14;
    localparam int DEPTH  = 16;
    localparam int PW     = ADDR_W + 1;

    logic                     clk;
    logic                     reset;
    logic                     wr_en;
    logic [VC_W-1:0]          wr_vc;
    logic [DATA_W-1:0]        wr_data;
    logic                     rd_en;
    logic [VC_W-1:0]          rd_vc;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic [NUM_VC-1:0]        full;
    logic [NUM_VC-1:0]        empty;
    logic [NUM_VC-1:0]        almost_full;
    logic [NUM_VC*PW-1:0]     ocup;
    logic [NUM_VC-1:0]        credit_out;
    logic [NUM_VC-1:0]        err;
    logic                     err_clr;

    vc_buffer_multi #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_VC(NUM_VC), .VC_W(VC_W), .AF_THRESH(AF_TH)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .ocup(ocup),
        .credit_out(credit_out), .err(err), .err_clr(err_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [DATA_W-1:0] exp_q [NUM_VC][$];
    logic [NUM_VC-1:0] m_err;
    logic [NUM_VC-1:0] m_credit;
    int total;
    int bad;
    logic chk_en;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NUM_VC; v++) exp_q[v].delete();
        m_err    = '0;
        m_credit = '0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            logic [NUM_VC-1:0] pops;
            logic [NUM_VC-1:0] sets;
            logic do_push;
            pops = '0;
            sets = '0;
            do_push = 1'b0;
            if (rd_en) begin
                if (exp_q[rd_vc].size() > 0) pops[rd_vc] = 1'b1;
                else sets[rd_vc] = 1'b1;
            end
            if (wr_en) begin
                if (exp_q[wr_vc].size() < DEPTH) do_push = 1'b1;
                else sets[wr_vc] = 1'b1;
            end
            if (pops != 0) void'(exp_q[rd_vc].pop_front());
            if (do_push) exp_q[wr_vc].push_back(wr_data);
            m_err    = (m_err & ~{NUM_VC{err_clr}}) | sets;
            m_credit = pops;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NUM_VC-1:0] e_empty, e_full, e_af;
            logic [DATA_W-1:0] e_data;
            for (int v = 0; v < NUM_VC; v++) begin
                int n;
                n = exp_q[v].size();
                e_empty[v] = (n == 0);
                e_full[v]  = (n == DEPTH);
                e_af[v]    = (n >= AF_TH);
                chk($sformatf("ocup%0d", v), 32'(ocup[v*PW +: PW]), 32'(n));
            end
            e_data = (exp_q[rd_vc].size() > 0) ? exp_q[rd_vc][0] : '0;
            chk("empty", 32'(empty), 32'(e_empty));
            chk("full", 32'(full), 32'(e_full));
            chk("almost_full", 32'(almost_full), 32'(e_af));
            chk("rd_data", rd_data, e_data);
            chk("rd_valid", 32'(rd_valid), 32'(exp_q[rd_vc].size() > 0));
            chk("credit_out", 32'(credit_out), 32'(m_credit));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic we, input logic [VC_W-1:0] wvc, input logic [DATA_W-1:0] wd,
                       input logic re, input logic [VC_W-1:0] rvc, input logic clr);
        wr_en = we; wr_vc = wvc; wr_data = wd;
        rd_en = re; rd_vc = rvc; err_clr = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle_rd(input logic [VC_W-1:0] rvc);
        rd_vc = rvc;
        #1;
    endtask

    function automatic logic [PW-1:0] oc(input int v);
        return ocup[v*PW +: PW];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        wr_en = 0; wr_vc = 0; wr_data = 0; rd_en = 0; rd_vc = 0; err_clr = 0;
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        // 1: reset state
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ocup", 32'(ocup), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_credit", 32'(credit_out), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk_en = 1'b1;

        // 2: fill VC2, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 2, 32'h100 + 32'(i), 0, 0, 0);
            if (i == 12) chk("af_after13", 32'(almost_full[2]), 32'h0);
            if (i == 13) chk("af_after14", 32'(almost_full[2]), 32'h1);
            if (i == 14) chk("full_after15", 32'(full[2]), 32'h0);
        end
        chk("full_after16", 32'(full[2]), 32'h1);
        cyc(1, 2, 32'hDEAD, 0, 0, 0);
        chk("ovf_err", 32'(err), 32'h4);
        chk("ovf_ocup", 32'(oc(2)), 32'd16);
        idle_rd(2);
        chk("head_vc2", rd_data, 32'h100);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 1, 2, 0);
            if (i == 0) chk("credit_first", 32'(credit_out), 32'h4);
        end
        chk("drain_empty", 32'(empty[2]), 32'h1);
        cyc(0, 0, 0, 0, 2, 0);
        chk("credit_gone", 32'(credit_out), 32'h0);

        // 3: simultaneous write/pop
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h200 + 32'(i), 0, 0, 0);
        cyc(1, 1, 32'h203, 1, 1, 0);
        chk("same_vc_ocup1", 32'(oc(1)), 32'd3);
        cyc(1, 0, 32'h300, 1, 1, 0);
        chk("diff_ocup0", 32'(oc(0)), 32'd1);
        chk("diff_ocup1", 32'(oc(1)), 32'd2);
        idle_rd(1);
        chk("vc1_head", rd_data, 32'h202);

        // 4: underflow and err_clr
        cyc(0, 0, 0, 1, 3, 0);
        chk("udf_err", 32'(err), 32'hC);
        chk("udf_ocup3", 32'(oc(3)), 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_err", 32'(err), 32'h0);
        cyc(0, 0, 0, 1, 3, 1);
        chk("clr_set_wins", 32'(err), 32'h8);
        cyc(0, 0, 0, 0, 0, 1);

        // 5: 40 write/pop pairs through VC0 (pointer wraps)
        for (int i = 0; i < 40; i++) cyc(1, 0, $urandom, 1, 0, 0);
        chk("wrap_ocup0", 32'(oc(0)), 32'd1);

        // 6: async reset mid-traffic
        for (int i = 0; i < 5; i++) cyc(1, 2, 32'h400 + 32'(i), 0, 0, 0);
        chk("pre_rst_ocup2", 32'(oc(2)), 32'd5);
        wr_en = 0; rd_en = 1; rd_vc = 2;
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_empty2", 32'(empty[2]), 32'h1);
        chk("async_ocup2", 32'(oc(2)), 32'd0);
        chk("async_credit", 32'(credit_out), 32'h0);
        chk("async_rd_valid", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1 rd_en = 0;
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 2, 0);
        chk("post_rst_credit", 32'(credit_out), 32'h0);
        chk("post_rst_empty", 32'(empty), 32'hF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
